// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared widths and instruction field positions for the
//                single-cycle MIPS-style datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    // rs / rt field positions within the instruction word
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;

    // Hardwired-zero register index
    localparam int ZERO_REG = 0;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x 32-bit general-purpose register file with two
//                combinational read ports (rs, rt taken from the instruction
//                word) and one synchronous write port. Register 0 reads zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import datapath_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction,
    input  logic [DATA_W_P-1:0] Data_in,
    input  logic                WE,
    input  logic [ADDR_W_P-1:0] AddrIn3,
    output logic [DATA_W_P-1:0] DOut1,
    output logic [DATA_W_P-1:0] DOut2
);

    localparam int                C_NUM_REGS = 2 ** ADDR_W_P;
    localparam logic [ADDR_W_P-1:0] C_ZERO_ADDR = ADDR_W_P'(ZERO_REG);

    logic [DATA_W_P-1:0] r_regs [C_NUM_REGS];

    logic [ADDR_W_P-1:0] w_rs_addr;
    logic [ADDR_W_P-1:0] w_rt_addr;
    logic                w_unused_bits;

    assign w_rs_addr = instruction[RS_MSB:RS_LSB];
    assign w_rt_addr = instruction[RT_MSB:RT_LSB];

    // Opcode, rd/shamt/funct and immediate bits play no part in register reads
    assign w_unused_bits = ^{instruction[31:RS_MSB+1], instruction[RT_LSB-1:0]};

    // Write port: async clear; writes to the zero register are dropped so it
    // keeps its reset value of zero forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE && (AddrIn3 != C_ZERO_ADDR)) begin
            r_regs[AddrIn3] <= Data_in;
        end
    end

    // Read ports: plain muxes, no bypass from the write port
    always_comb begin
        DOut1 = r_regs[w_rs_addr];
        DOut2 = r_regs[w_rt_addr];
    end

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] Data_in;
    logic        WE;
    logic [4:0]  AddrIn3;
    logic [31:0] DOut1;
    logic [31:0] DOut2;

    int n_checks = 0;
    int n_pass   = 0;

    register_file dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .Data_in     (Data_in),
        .WE          (WE),
        .AddrIn3     (AddrIn3),
        .DOut1       (DOut1),
        .DOut2       (DOut2)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Single write cycle; leaves us 1 ns after the edge with WE low
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        WE      = 1'b1;
        AddrIn3 = addr;
        Data_in = data;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b0, rs, rt, 16'h0000};
    endfunction

    initial begin
        rst         = 1'b1;
        WE          = 1'b0;
        AddrIn3     = '0;
        Data_in     = '0;
        instruction = 32'h00a60000;

        #2;
        check("reset_dout1", DOut1, 32'h0);
        check("reset_dout2", DOut2, 32'h0);

        #10;                       // t=12, between edges
        rst = 1'b0;

        write_reg(5'd5, 32'd2);
        write_reg(5'd6, 32'd4);
        instruction = 32'h00a60000;
        #1;
        check("rd_rs5", DOut1, 32'd2);
        check("rd_rt6", DOut2, 32'd4);

        // Both ports on one register
        instruction = mk_instr(5'd6, 5'd6);
        #1;
        check("same_reg_p1", DOut1, 32'd4);
        check("same_reg_p2", DOut2, 32'd4);

        // Ignored instruction bits set
        instruction = 32'hFCA6FFFF;
        #1;
        check("ign_bits_p1", DOut1, 32'd2);
        check("ign_bits_p2", DOut2, 32'd4);

        // Write to register 0 is discarded
        write_reg(5'd0, 32'hDEADBEEF);
        instruction = 32'h00000000;
        #1;
        check("r0_p1", DOut1, 32'h0);
        check("r0_p2", DOut2, 32'h0);
        instruction = mk_instr(5'd0, 5'd5);
        #1;
        check("r0_mix_p2", DOut2, 32'd2);

        // WE low holds state across several edges
        WE      = 1'b0;
        AddrIn3 = 5'd5;
        Data_in = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        instruction = mk_instr(5'd5, 5'd6);
        #1;
        check("we0_hold", DOut1, 32'd2);

        // Same-cycle read/write: old before edge, new after
        @(posedge clk);
        #1;
        WE      = 1'b1;
        AddrIn3 = 5'd5;
        Data_in = 32'd7;
        #1;
        check("pre_edge_old", DOut1, 32'd2);
        @(posedge clk);
        #1;
        WE = 1'b0;
        check("post_edge_new", DOut1, 32'd7);
        check("post_edge_rt", DOut2, 32'd4);

        // Async reset mid-cycle
        #2;                         // 3 ns after the edge
        rst = 1'b1;
        #1;
        check("async_rst_p1", DOut1, 32'h0);
        check("async_rst_p2", DOut2, 32'h0);

        // Write attempt during reset is ignored
        WE      = 1'b1;
        AddrIn3 = 5'd6;
        Data_in = 32'd9;
        @(posedge clk);
        #1;
        WE = 1'b0;
        check("rst_wr_ignored", DOut2, 32'h0);
        #2;
        rst = 1'b0;
        #1;

        // Every register reads zero after reset release
        for (int i = 0; i < 32; i += 2) begin
            instruction = mk_instr(5'(i), 5'(i + 1));
            #1;
            check($sformatf("post_rst_r%0d", i), DOut1, 32'h0);
            check($sformatf("post_rst_r%0d", i + 1), DOut2, 32'h0);
        end

        // Register file still writable after reset
        write_reg(5'd31, 32'hA5A5_5A5A);
        instruction = mk_instr(5'd31, 5'd5);
        #1;
        check("post_rst_wr31", DOut1, 32'hA5A5_5A5A);
        check("post_rst_r5", DOut2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
